// File: rtl/debounce_pkg.sv
// Shared types, limits and helpers for the input debouncer.
// Edge outputs are enabled with DEBOUNCE_EDGE_EN.
package debounce_pkg;

    localparam int MAX_STABLE_CYCLES = 65535;
    localparam int CNT_MAX_W         = 16;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef enum logic {
        BIT_STABLE,
        BIT_PENDING
    } bit_state_t;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced bit: two-flop synchronizer, stability counter, output flop.
// flip is a registered pulse coincident with the first cycle of a new o.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter logic INIT_BIT      = 1'b0,
    parameter int   STABLE_CYCLES = 4
) (
    input  logic CLK,
    input  logic ASYNCRESET,
    input  logic i,
    output logic o,
    output logic flip
);

    localparam int            CW        = cnt_width(STABLE_CYCLES);
    localparam cnt_t          LAST_FULL = cnt_t'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LAST      = LAST_FULL[CW-1:0];

    logic          s1_q;
    logic          s2_q;
    logic          o_q;
    logic          o_d;
    logic          flip_q;
    logic          flip_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    bit_state_t    state;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            s1_q   <= INIT_BIT;
            s2_q   <= INIT_BIT;
            o_q    <= INIT_BIT;
            cnt_q  <= '0;
            flip_q <= 1'b0;
        end else begin
            s1_q   <= i;
            s2_q   <= s1_q;
            o_q    <= o_d;
            cnt_q  <= cnt_d;
            flip_q <= flip_d;
        end
    end

    // Any return to the output value drops all accumulated credit.
    always_comb begin
        state  = (s2_q == o_q) ? BIT_STABLE : BIT_PENDING;
        cnt_d  = '0;
        o_d    = o_q;
        flip_d = 1'b0;
        unique case (state)
            BIT_STABLE: begin
                cnt_d = '0;
            end
            BIT_PENDING: begin
                if (cnt_q == LAST) begin
                    o_d    = s2_q;
                    flip_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign o    = o_q;
    assign flip = flip_q;

endmodule

// File: rtl/input_debouncer.sv
// Bank of independent debounced inputs feeding a register stage.
// Define DEBOUNCE_EDGE_EN to add per-bit RISE/FALL outputs.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter     INIT          = 2'b10,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic             CHANGED
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
`endif
);

    logic [WIDTH-1:0] flip;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_cycles
        $fatal(1, "input_debouncer: STABLE_CYCLES out of range");
    end

    if ($bits(INIT) != WIDTH) begin : g_bad_init
        $fatal(1, "input_debouncer: INIT width differs from WIDTH");
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        debounce_cell #(
            .INIT_BIT      (INIT[b]),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_cell (
            .CLK        (CLK),
            .ASYNCRESET (ASYNCRESET),
            .i          (I[b]),
            .o          (O[b]),
            .flip       (flip[b])
        );
    end

    assign CHANGED = |flip;

`ifdef DEBOUNCE_EDGE_EN
    // flip and O are both registers, so the edge flags stay glitch-free.
    assign RISE = flip & O;
    assign FALL = flip & ~O;
`endif

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Debounces and synchronizes a bank of raw asynchronous input bits before they reach the register stage. Each bit passes through a two-flop synchronizer and a per-bit stability counter. The registered output changes only after the synchronized input has held a new value for a programmable number of consecutive cycles. Its output `O` drives the downstream flip-flop bank's `I` directly, shares that bank's clock and reset, and uses the same per-bit reset values.

## Interface
- `WIDTH`, default 2: number of independent input bits.
- `INIT`, default `2'b10` (`WIDTH` bits): per-bit reset value for synchronizer flops and `O`; matches the downstream bank's per-bit init.
- `STABLE_CYCLES`, default 4: consecutive differing cycles required before a bit flips; legal range 1..65535.

Ports:
- `CLK` input, 1: sole clock, rising edge.
- `ASYNCRESET` input, 1: reset, asynchronous, active-high.
- `I` input, `WIDTH`: raw asynchronous inputs.
- `O` output, `WIDTH`: debounced, registered value.
- `CHANGED` output, 1: one-cycle pulse when any bit of `O` flips.
- `RISE` output, `WIDTH`: present only with `DEBOUNCE_EDGE_EN`; see Configuration.
- `FALL` output, `WIDTH`: present only with `DEBOUNCE_EDGE_EN`; see Configuration.

## Operation
- Reset, while `ASYNCRESET` is high, immediate:
  - `s1`, `s2`, `O` = `INIT`.
  - All counters = 0.
  - `CHANGED`, `RISE`, `FALL` = 0.
- Synchronizer, per bit: `s1` <= `I`, `s2` <= `s1`.
- Per-bit state, two implicit states:
  - STABLE (`s2 == O`): counter <= 0.
  - PENDING (`s2 != O`): if counter == `STABLE_CYCLES`-1, then `O` <= `s2` and counter <= 0; else counter <= counter+1.
- A glitch that returns `s2` to `O` before the threshold clears the counter. There is no partial credit; the next deviation starts again from 0.
- Counter width: `$clog2(STABLE_CYCLES)`, minimum 1. The counter never exceeds `STABLE_CYCLES`-1, so there is no wrap-around.
- `CHANGED` is a registered pulse, high in the cycle after the edge where any `O` bit updates. It is also high during the cycle in which the new `O` value is first visible.
- Bits are fully independent. Several bits may flip on the same edge; `CHANGED` then pulses once.
- Deasserting reset mid-count discards all progress; operation restarts from `INIT`.

## Timing
- Latency: if `I[b]` changes before edge k and stays there, `O[b]` updates on edge k+1+`STABLE_CYCLES`.
- Minimum latency (`STABLE_CYCLES`=1): 2 edges.
- Throughput: one decision per bit per cycle.
- Steady-state minimum pulse width of `O` toggles: `STABLE_CYCLES` cycles.
- All outputs are registered; there are no combinational paths from `I`.
- Release of `ASYNCRESET` is assumed synchronized externally; the block adds no reset synchronizer.

## Configuration
- `DEBOUNCE_EDGE_EN` defined:
  - Adds registered `RISE`/`FALL` outputs.
  - `RISE[b]` = 1 for exactly one cycle, coincident with `O[b]` going 0→1.
  - `FALL[b]` likewise for 1→0.
  - Both reset to 0.
- `DEBOUNCE_EDGE_EN` undefined: the ports and their flops do not exist; all other behaviour is identical.

## Structure
- Shared package `debounce_pkg`:
  - `MAX_STABLE_CYCLES` = 65535.
  - Function `cnt_width(n)` = max(1, `$clog2(n)`).
  - Typedef for the per-bit counter.
- Sub-module `debounce_cell`: one bit of synchronizer, counter and output flop.
  - Parameters: `INIT_BIT`, `STABLE_CYCLES`.
  - Ports: `CLK`, `ASYNCRESET`, `i`, `o`, `flip`.
  - The top generates `WIDTH` instances and ORs their registered `flip` into `CHANGED`.
- Parameter checks are elaboration-time assertions: `STABLE_CYCLES` in range, `INIT` width equals `WIDTH`.

## Test plan
All scenarios use `WIDTH`=2, `INIT`=`2'b10`, `STABLE_CYCLES`=4 unless noted.
1. Reset: assert `ASYNCRESET` mid-cycle with `I`=`2'b01` → `O`=`2'b10` immediately and `CHANGED`=0. Hold `I`=`2'b10` after release → `O` stays `2'b10` and no `CHANGED`.
2. Clean step: `I` `2'b10`→`2'b11` before edge 10 → `O`=`2'b11` after edge 15. `CHANGED` is high for exactly the cycle following edge 15. `O` does not change earlier.
3. Glitch rejection: bit0 high for 3 cycles, low for 1, then high steadily → the first pulse never reaches `O`. `O[0]` rises 5 edges after the final rise is sampled.
4. Simultaneous flips: `I` `2'b10`→`2'b01` in one cycle → both bits flip on the same edge, `O`=`2'b01`, and `CHANGED` pulses once.
5. Reset mid-count: start a bit0 rise, then assert `ASYNCRESET` after 2 counted cycles → `O`=`2'b10` and counters clear. After release, a full 1+4 edges are needed again.
6. With `DEBOUNCE_EDGE_EN` and `STABLE_CYCLES`=1: toggle bit1 1→0→1, each level held 3 cycles → `FALL[1]` pulse, then `RISE[1]` pulse, each 1 cycle and coincident with the `O[1]` change, 2 edges after the respective input change.
